// File: rtl/mac_lookup.sv
// Destination-MAC resolver: linear scan of an external table, one entry per cycle; group dst floods after 1 cycle, hit at k after k+2, miss after NUM_ENTRIES+1.
// One lookup in flight: req_ready only when idle; the registered response is held until resp_ready.
module mac_lookup #(
  parameter int NUM_PORTS   = 4,
  parameter int NUM_ENTRIES = NUM_PORTS * 4,
  parameter int MAC_W       = 48
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [MAC_W-1:0]               req_dst_mac,
  input  logic [$clog2(NUM_PORTS)-1:0]   req_src_port,
  output logic [$clog2(NUM_ENTRIES)-1:0] rd_idx,
  input  logic                           rd_valid,
  input  logic [MAC_W-1:0]               rd_mac,
  input  logic [$clog2(NUM_PORTS)-1:0]   rd_port,
  output logic                           hit_inc,
  output logic [$clog2(NUM_ENTRIES)-1:0] hit_idx,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_hit,
  output logic [$clog2(NUM_PORTS)-1:0]   resp_port,
  output logic                           resp_flood,
  output logic                           resp_drop
);

  localparam int PW        = $clog2(NUM_PORTS);
  localparam int IW        = $clog2(NUM_ENTRIES);
  localparam int GROUP_BIT = 40;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTRIES - 1);

  logic [1:0]       state;
  logic [MAC_W-1:0] lat_mac;
  logic [PW-1:0]    lat_src;
  logic             match;

  assign req_ready = (state == IDLE);
  assign match     = rd_valid && (rd_mac == lat_mac);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_mac    <= '0;
      lat_src    <= '0;
      rd_idx     <= '0;
      hit_inc    <= 1'b0;
      hit_idx    <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_port  <= '0;
      resp_flood <= 1'b0;
      resp_drop  <= 1'b0;
    end else begin
      hit_inc <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_mac <= req_dst_mac;
            lat_src <= req_src_port;
            rd_idx  <= '0;
            // Group bit is decided on the incoming address so the flood answer lands one cycle after accept.
            if (req_dst_mac[GROUP_BIT]) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_hit   <= 1'b0;
              resp_port  <= '0;
              resp_flood <= 1'b1;
              resp_drop  <= 1'b0;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (match) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_port  <= rd_port;
            resp_flood <= 1'b0;
            resp_drop  <= (rd_port == lat_src);
            hit_inc    <= 1'b1;
            hit_idx    <= rd_idx;
          end else if (rd_idx == LAST_IDX) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_port  <= '0;
            resp_flood <= 1'b1;
            resp_drop  <= 1'b0;
          end else begin
            rd_idx <= rd_idx + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_lookup.sv
// Scoreboarded bench for mac_lookup: directed lookups push expectations, a negedge monitor checks responses and hit pulses.
module tb_mac_lookup;

  localparam int NP = 4;
  localparam int NE = 16;
  localparam int MW = 48;
  localparam int PW = 2;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [MW-1:0] req_dst_mac;
  logic [PW-1:0] req_src_port;
  logic [IW-1:0] rd_idx;
  logic          rd_valid;
  logic [MW-1:0] rd_mac;
  logic [PW-1:0] rd_port;
  logic          hit_inc;
  logic [IW-1:0] hit_idx;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_hit;
  logic [PW-1:0] resp_port;
  logic          resp_flood;
  logic          resp_drop;

  always #5 clk = ~clk;

  mac_lookup #(.NUM_PORTS(NP), .NUM_ENTRIES(NE), .MAC_W(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_mac(req_dst_mac), .req_src_port(req_src_port),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_mac(rd_mac), .rd_port(rd_port),
    .hit_inc(hit_inc), .hit_idx(hit_idx),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_port(resp_port),
    .resp_flood(resp_flood), .resp_drop(resp_drop)
  );

  // Address table model, read combinationally at rd_idx
  logic          tbl_vld  [NE];
  logic [MW-1:0] tbl_mac  [NE];
  logic [PW-1:0] tbl_port [NE];
  assign rd_valid = tbl_vld[rd_idx];
  assign rd_mac   = tbl_mac[rd_idx];
  assign rd_port  = tbl_port[rd_idx];

  typedef struct {
    int            t0;
    int            lat;
    logic          hit;
    logic [PW-1:0] port;
    logic          flood;
    logic          drop;
  } exp_t;

  exp_t exp_q[$];
  int   hexp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   resp_seen = 1'b0;
  exp_t mon_e;
  int   mon_h;

  localparam logic [MW-1:0] MAC_A = 48'h0011_2233_4455;
  localparam logic [MW-1:0] MAC_B = 48'h00AA_BBCC_DDEE;
  localparam logic [MW-1:0] MAC_C = 48'h0200_0000_BEEF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: responses are compared every cycle they are held, popped on handshake
  always @(negedge clk) begin
    if (rst_n && hit_inc) begin
      if (hexp_q.size() == 0) fail("unexpected hit_inc");
      else begin
        mon_h = hexp_q.pop_front();
        chk("hit_idx", 64'(hit_idx), 64'(mon_h));
      end
    end
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) fail("unexpected resp_valid");
      else begin
        mon_e = exp_q[0];
        if (!resp_seen) chk("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
        chk("resp_hit", 64'(resp_hit), 64'(mon_e.hit));
        if (mon_e.hit) chk("resp_port", 64'(resp_port), 64'(mon_e.port));
        chk("resp_flood", 64'(resp_flood), 64'(mon_e.flood));
        chk("resp_drop", 64'(resp_drop), 64'(mon_e.drop));
        chk("req_ready_busy", 64'(req_ready), 64'(0));
        resp_seen = 1'b1;
        if (resp_ready) begin
          void'(exp_q.pop_front());
          resp_seen = 1'b0;
        end
      end
    end
  end

  task automatic clear_table();
    for (int i = 0; i < NE; i++) begin
      tbl_vld[i]  = 1'b0;
      tbl_mac[i]  = '0;
      tbl_port[i] = '0;
    end
  endtask

  task automatic set_entry(input int idx, input logic v, input logic [MW-1:0] mac, input logic [PW-1:0] port);
    tbl_vld[idx]  = v;
    tbl_mac[idx]  = mac;
    tbl_port[idx] = port;
  endtask

  task automatic issue(input logic [MW-1:0] mac, input logic [PW-1:0] src, input int lat,
                       input logic hit, input logic [PW-1:0] port, input logic flood,
                       input logic drop, input int hidx);
    exp_t e;
    int   n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) fail("req_ready timeout");
    req_valid    = 1'b1;
    req_dst_mac  = mac;
    req_src_port = src;
    e.t0 = cyc; e.lat = lat; e.hit = hit; e.port = port; e.flood = flood; e.drop = drop;
    exp_q.push_back(e);
    if (hidx >= 0) hexp_q.push_back(hidx);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      fail("response timeout");
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    chk("hit_inc_pending", 64'(hexp_q.size()), 64'(0));
    hexp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_dst_mac  = '0;
    req_src_port = '0;
    resp_ready   = 1'b1;
    clear_table();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_hit_inc", 64'(hit_inc), 64'(0));
    chk("rst_rd_idx", 64'(rd_idx), 64'(0));
    chk("rst_hit_idx", 64'(hit_idx), 64'(0));
    chk("rst_resp_fields", 64'({resp_hit, resp_port, resp_flood, resp_drop}), 64'(0));
    rst_n = 1'b1;
    chk("req_ready_after_reset", 64'(req_ready), 64'(1));
    @(posedge clk); #1;

    // Broadcast from src 1: flood in one cycle, no scan, no hit pulse
    set_entry(5, 1'b1, MAC_A, 2'd2);
    issue(48'hFFFF_FFFF_FFFF, 2'd1, 1, 1'b0, 2'd0, 1'b1, 1'b0, -1);
    drain();
    // Non-broadcast multicast also takes the group path
    issue(48'h0100_5E00_0001, 2'd0, 1, 1'b0, 2'd0, 1'b1, 1'b0, -1);
    drain();
    // Hit at index 5 from src 0, then from src 2 (same port -> drop)
    issue(MAC_A, 2'd0, 7, 1'b1, 2'd2, 1'b0, 1'b0, 5);
    drain();
    issue(MAC_A, 2'd2, 7, 1'b1, 2'd2, 1'b0, 1'b1, 5);
    drain();

    // Empty table: full scan then flood
    clear_table();
    issue(48'h0000_0000_0001, 2'd3, 17, 1'b0, 2'd0, 1'b1, 1'b0, -1);
    drain();

    // Duplicates at 3 and 9 (invalid copy at 2): lowest valid index wins
    set_entry(2, 1'b0, MAC_B, 2'd2);
    set_entry(3, 1'b1, MAC_B, 2'd1);
    set_entry(9, 1'b1, MAC_B, 2'd3);
    issue(MAC_B, 2'd0, 5, 1'b1, 2'd1, 1'b0, 1'b0, 3);
    drain();

    // First and last index boundaries, plus a one-bit near miss
    clear_table();
    set_entry(0, 1'b1, MAC_A, 2'd3);
    set_entry(15, 1'b1, MAC_C, 2'd0);
    issue(MAC_A, 2'd1, 2, 1'b1, 2'd3, 1'b0, 1'b0, 0);
    drain();
    issue(MAC_C, 2'd2, 17, 1'b1, 2'd0, 1'b0, 1'b0, 15);
    drain();
    issue(MAC_C ^ 48'h1, 2'd2, 17, 1'b0, 2'd0, 1'b1, 1'b0, -1);
    drain();

    // Backpressure: response held for 10 cycles with resp_ready low
    clear_table();
    set_entry(5, 1'b1, MAC_A, 2'd2);
    resp_ready = 1'b0;
    issue(MAC_A, 2'd0, 7, 1'b1, 2'd2, 1'b0, 1'b0, 5);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!resp_valid) fail("stall resp_valid timeout");
    repeat (10) @(posedge clk);
    #1;
    chk("stall_resp_valid", 64'(resp_valid), 64'(1));
    chk("stall_req_ready", 64'(req_ready), 64'(0));
    resp_ready = 1'b1;
    drain();

    // Reset mid-scan: lookup abandoned, nothing emitted afterwards
    req_valid    = 1'b1;
    req_dst_mac  = MAC_A;
    req_src_port = 2'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("scan_progress_idx", 64'(rd_idx), 64'(2));
    rst_n = 1'b0;
    #1;
    chk("async_reset_rd_idx", 64'(rd_idx), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("req_ready_after_midscan_reset", 64'(req_ready), 64'(1));
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (resp_valid || hit_inc) seen++;
    end
    chk("silent_after_reset", 64'(seen), 64'(0));
    #1;

    // Normal operation resumes after the abandoned lookup
    issue(MAC_A, 2'd1, 7, 1'b1, 2'd2, 1'b0, 1'b0, 5);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
